// File: rtl/sobel_window_engine.sv
// sobel_window_engine: sliding 3x3 window, Sobel |Gx|+|Gy| saturated to 8 bits, 3-clock pipeline.
// Define SOBEL_THRESHOLD_EN to binarize the magnitude against thresh_i instead.
module sobel_window_engine #(
    parameter int IMG_WIDTH = 640
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic [7:0] row0_i,
    input  logic [7:0] row1_i,
    input  logic [7:0] row2_i,
    input  logic       valid_i,
`ifdef SOBEL_THRESHOLD_EN
    input  logic [7:0] thresh_i,
`endif
    output logic [7:0] pix_o,
    output logic       pix_valid_o,
    output logic       line_end_o
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);
    // win_q[row][col]: row 0 = bottom (newest line), col 2 = newest column
    logic [2:0][2:0][7:0] win_q, win_d;
    logic [CW-1:0]        col_q, col_d;
    logic                 vld1_q, vld1_d, le1_q, le1_d;
    logic signed [10:0]   gx_q, gx_d, gy_q, gy_d;
    logic                 vld2_q, le2_q;
    logic [7:0]           pix_q, pix_d;
    logic                 vld3_q, le3_q;
    logic [10:0]          abs_x, abs_y, mag;

    function automatic logic signed [10:0] col_sum(input int c);
        return 11'(win_q[2][c]) + 11'({win_q[1][c], 1'b0}) + 11'(win_q[0][c]);
    endfunction

    function automatic logic signed [10:0] row_sum(input int r);
        return 11'(win_q[r][0]) + 11'({win_q[r][1], 1'b0}) + 11'(win_q[r][2]);
    endfunction

    always_comb begin
        col_d  = valid_i ? ((col_q == LAST) ? '0 : col_q + 1'b1) : col_q;
        win_d  = valid_i ? {{row2_i, win_q[2][2:1]}, {row1_i, win_q[1][2:1]}, {row0_i, win_q[0][2:1]}} : win_q;
        vld1_d = valid_i && (col_q >= CW'(2));
        le1_d  = valid_i && (col_q == LAST);
        gx_d   = col_sum(2) - col_sum(0);
        gy_d   = row_sum(0) - row_sum(2);
        abs_x  = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        abs_y  = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        mag    = abs_x + abs_y;
`ifdef SOBEL_THRESHOLD_EN
        pix_d  = (mag > {3'b000, thresh_i}) ? 8'hff : 8'h00;
`else
        pix_d  = (mag > 11'd255) ? 8'hff : mag[7:0];
`endif
    end

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            win_q  <= '0;
            col_q  <= '0;
            vld1_q <= 1'b0;
            le1_q  <= 1'b0;
            gx_q   <= '0;
            gy_q   <= '0;
            vld2_q <= 1'b0;
            le2_q  <= 1'b0;
            pix_q  <= '0;
            vld3_q <= 1'b0;
            le3_q  <= 1'b0;
        end else begin
            win_q  <= win_d;
            col_q  <= col_d;
            vld1_q <= vld1_d;
            le1_q  <= le1_d;
            gx_q   <= gx_d;
            gy_q   <= gy_d;
            vld2_q <= vld1_q;
            le2_q  <= le1_q;
            pix_q  <= pix_d;
            vld3_q <= vld2_q;
            le3_q  <= le2_q;
        end
    end

    assign pix_o       = pix_q;
    assign pix_valid_o = vld3_q;
    assign line_end_o  = le3_q;
endmodule

// File: tb/tb_sobel_window_engine.sv
// tb_sobel_window_engine: directed and random stimulus against an image-level Sobel model.
module tb_sobel_window_engine;
    localparam int W = 8;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] row0, row1, row2, thresh;
    logic       valid = 1'b0;
    logic [7:0] pix;
    logic       pvld, ple;

    sobel_window_engine #(.IMG_WIDTH(W)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst_n),
        .row0_i(row0), .row1_i(row1), .row2_i(row2), .valid_i(valid),
`ifdef SOBEL_THRESHOLD_EN
        .thresh_i(thresh),
`endif
        .pix_o(pix), .pix_valid_o(pvld), .line_end_o(ple)
    );

    always #5 clk = ~clk;

    typedef struct { int due; int pix; bit le; } exp_t;
    exp_t q[$];
    int img[3][W];
    int tcol = 0, cyc = 0, n_chk = 0, n_pass = 0, n_pulse = 0, n_le = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input int expv);
        n_chk++;
        assert (obs === 16'(expv)) n_pass++;
        else $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    endtask

    // Sobel on the stored image: the window ends at the column just received
    task automatic model(input int a0, input int a1, input int a2);
        int gx, gy, mag, e;
        img[0][tcol] = a0; img[1][tcol] = a1; img[2][tcol] = a2;
        if (tcol >= 2) begin
            gx = 0; gy = 0;
            for (int r = 0; r < 3; r++) gx += ((r == 1) ? 2 : 1) * (img[r][tcol] - img[r][tcol-2]);
            for (int k = 0; k < 3; k++) gy += ((k == 1) ? 2 : 1) * (img[0][tcol-2+k] - img[2][tcol-2+k]);
            mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
`ifdef SOBEL_THRESHOLD_EN
            e = (mag > int'(thresh)) ? 255 : 0;
`else
            e = (mag > 255) ? 255 : mag;
`endif
            q.push_back('{cyc + 3, e, tcol == W - 1});
        end
        tcol = (tcol + 1) % W;
    endtask

    task automatic step(input logic v, input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
        valid = v; row0 = a0; row1 = a1; row2 = a2;
        if (v && rst_n) model(a0, a1, a2);
        @(posedge clk);
        cyc++;
        #1;
        if (pvld) n_pulse++;
        if (pvld && ple) n_le++;
        if (q.size() > 0 && q[0].due == cyc) begin
            chk("valid", 16'(pvld), 1);
            chk("pix", 16'(pix), q[0].pix);
            chk("line_end", 16'(ple), int'(q[0].le));
            void'(q.pop_front());
        end else chk("idle_valid", 16'(pvld), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic hgrad_line(input int gap);
        for (int c = 0; c < W; c++) begin
            step(1'b1, 8'd20, 8'd10, 8'd10);
            idle(gap);
        end
    endtask

    initial begin
        thresh = 8'd0;
        row0 = '0; row1 = '0; row2 = '0;
        #1;
        chk("reset_pix", 16'(pix), 0);
        chk("reset_valid", 16'(pvld), 0);
        chk("reset_line_end", 16'(ple), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        // flat field, two lines
        n_pulse = 0; n_le = 0;
        for (int i = 0; i < 2 * W; i++) step(1'b1, 8'd100, 8'd100, 8'd100);
        idle(4);
        chk("flat_pulses", 16'(n_pulse), 12);
        chk("flat_line_ends", 16'(n_le), 2);
        // horizontal gradient, continuous
        hgrad_line(0);
        idle(4);
        // vertical edge
        for (int c = 0; c < W; c++) begin
            logic [7:0] p;
            p = (c < 4) ? 8'd0 : 8'd200;
            step(1'b1, p, p, p);
        end
        idle(4);
        // bubbles: valid 1-0-0-1 with garbage on idle cycles
        n_pulse = 0;
        hgrad_line(2);
        idle(4);
        chk("bubble_pulses", 16'(n_pulse), W - 2);
        // random pixels and random valid
        for (int i = 0; i < 40 * W; i++) begin
            if ($urandom_range(0, 9) < 7) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
            else idle(1);
            while (tcol != 0 && i == 40 * W - 1) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        end
        idle(4);
        // reset mid-line after column 4
        for (int c = 0; c < 5; c++) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pix", 16'(pix), 0);
        chk("midrst_valid", 16'(pvld), 0);
        chk("midrst_line_end", 16'(ple), 0);
        q.delete();
        tcol = 0;
        idle(2);
        rst_n = 1'b1;
        for (int c = 0; c < W; c++) step(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        idle(4);
`ifdef SOBEL_THRESHOLD_EN
        thresh = 8'd30; hgrad_line(0); idle(4);
        thresh = 8'd40; hgrad_line(0); idle(4);
        thresh = 8'd50; hgrad_line(0); idle(4);
`endif
        chk("queue_drained", 16'(q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sobel_window_engine.md
# sobel_window_engine

Consumes the three vertically aligned pixel streams from the two-line FIFO stage, newest row plus two delayed rows, with a shared column-valid strobe. It assembles a sliding 3x3 window and computes the Sobel gradient magnitude |Gx| + |Gy|, saturated to 8 bits. It emits one magnitude pixel per fully populated window through a fixed 3-clock pipeline. It is the direct downstream stage of the line-buffer block and feeds the output or threshold writer.

## Interface
- IMG_WIDTH, 640, pixels per line; must equal the line-buffer depth; legal range ≥ 3.
- sys_clk_i  input  1  single system clock, rising edge.
- sys_rst_i  input  1  asynchronous, active-low reset.
- row0_i  input  8  newest (bottom) line pixel.
- row1_i  input  8  middle line pixel, delayed one line.
- row2_i  input  8  oldest (top) line pixel, delayed two lines.
- valid_i  input  1  all three row inputs hold a valid column this cycle; driven by the line-buffer done strobe.
- thresh_i  input  8  binarization threshold; present only with SOBEL_THRESHOLD_EN.
- pix_o  output  8  gradient magnitude pixel.
- pix_valid_o  output  1  pix_o valid this cycle.
- line_end_o  output  1  pix_o is the last output of the current line; qualified by pix_valid_o.

## Operation
- **Column counter.**
  - col_cnt is $clog2(IMG_WIDTH) bits and advances only on valid_i.
  - It wraps from IMG_WIDTH-1 to 0.
- **Window.**
  - The window holds 3 rows x 3 columns; column c0 is the oldest, c2 the newest.
  - On valid_i, each row shifts left and {row2_i,row1_i,row0_i} loads into c2.
  - With valid_i low, the window holds its contents.
- **Stage 1 (window qualify).**
  - win_vld is set on a valid_i edge when col_cnt ≥ 2 before the increment.
  - The columns 0 and 1 of each line produce no output; windows never straddle lines.
  - Result: IMG_WIDTH-2 outputs per line; no border padding.
- **Stage 2 (gradients).** Registered, 11-bit signed.
  - Gx = (r·c2 weighted) − (r·c0 weighted), with row weights 1,2,1 (top, mid, bottom).
  - Gy = (row0 c0 + 2·row0 c1 + row0 c2) − (row2 c0 + 2·row2 c1 + row2 c2).
  - Range of each: ±1020.
- **Stage 3 (magnitude).** Registered.
  - mag = |Gx| + |Gy| is 11-bit unsigned, range 0..2040.
  - pix_o = min(mag, 255).
- **Line end.** line_end_o travels with the window tagged col_cnt = IMG_WIDTH-1.
- **No stall.** Every stage advances each clock, and the valid flags propagate bubbles. Gaps in valid_i produce gaps in pix_valid_o and never corrupt the window.
- **Frame boundaries.** The block is frame-agnostic; the upstream stage guarantees rows are aligned.

## Timing
- **Reset (sys_rst_i low, asynchronous).**
  - Clears the window, col_cnt, all pipeline registers, pix_o = 0, pix_valid_o = 0 and line_end_o = 0.
  - Deassertion takes effect on the next rising edge.
- **Latency.** Input sampled at edge E0 produces pix_valid_o and pix_o registered at edge E0+2, i.e. 3 clocks from valid_i to output.
- **Throughput.** One pixel per clock sustained.
- **Wrap and input together.** The edge that wraps col_cnt to 0 is the same edge that loads the last column; its window is still emitted with line_end_o = 1.
- **Reset mid-line.** Partial window contents are discarded. The first output after reset requires 3 fresh valid columns starting at col_cnt = 0.
- **Saturation.** Any mag ≥ 255 yields exactly 255; there is no wrap-around.

## Configuration
- **SOBEL_THRESHOLD_EN defined.**
  - The thresh_i port exists.
  - Stage 3 outputs 255 if mag > thresh_i, else 0.
  - Latency is unchanged.
- **SOBEL_THRESHOLD_EN undefined.**
  - The thresh_i port is absent.
  - pix_o is the saturated magnitude.

## Test plan
- **Flat field.** IMG_WIDTH=8, all rows = 100, valid_i continuous for 2 lines.
  - 12 pulses on pix_valid_o, all pix_o = 0.
  - line_end_o on the 6th and 12th pulses.
- **Horizontal gradient.** row2 = 10, row1 = 10, row0 = 20 constant.
  - Every output pix_o = 40 (Gy = 40, Gx = 0).
- **Vertical edge.** Columns 0–3 = 0 and columns 4–7 = 200 on all rows.
  - Outputs for windows ending at columns 2..7 are 0, 0, 255, 255, 0, 0.
  - The 255s come from Gx = 800, saturated.
- **Bubbles.** The horizontal-gradient stimulus with valid_i toggled 1-0-0-1.
  - Same output values and count as the continuous run.
  - Each pix_valid_o follows its final contributing valid_i by exactly 3 clocks.
- **Reset mid-line.** Assert sys_rst_i low asynchronously after column 4.
  - All outputs go to 0 immediately.
  - After release, the first pix_valid_o appears 3 clocks after the 3rd new valid column.
- **Threshold (SOBEL_THRESHOLD_EN).** Horizontal-gradient stimulus (mag 40).
  - thresh_i = 30 gives pix_o = 255.
  - thresh_i = 40 gives 0.
  - thresh_i = 50 gives 0.
